// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, state codes, mux select codes and the control-word
// type shared by the multi-cycle MIPS controller and its output decoder.
package mc_ctrl_pkg;

   // Instruction opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // State codes, visible on the debug port
   localparam logic [3:0] ST_FETCH    = 4'd0;
   localparam logic [3:0] ST_DECODE   = 4'd1;
   localparam logic [3:0] ST_MEM_ADDR = 4'd2;
   localparam logic [3:0] ST_MEM_RD   = 4'd3;
   localparam logic [3:0] ST_MEM_WB   = 4'd4;
   localparam logic [3:0] ST_MEM_WR   = 4'd5;
   localparam logic [3:0] ST_R_EXEC   = 4'd6;
   localparam logic [3:0] ST_R_WB     = 4'd7;
   localparam logic [3:0] ST_BRANCH   = 4'd8;
   localparam logic [3:0] ST_I_EXEC   = 4'd9;
   localparam logic [3:0] ST_I_WB     = 4'd10;
   localparam logic [3:0] ST_JUMP     = 4'd11;
   localparam logic [3:0] ST_TRAP     = 4'd12;

   // Datapath mux select codes
   localparam logic [1:0] REG_DST_RT        = 2'd0;
   localparam logic [1:0] REG_DST_RD        = 2'd1;
   localparam logic [1:0] REG_DST_RA        = 2'd2;
   localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'd0;
   localparam logic [1:0] MEM_TO_REG_MDR    = 2'd1;
   localparam logic [1:0] MEM_TO_REG_PC     = 2'd2;
   localparam logic [1:0] ALU_B_RT          = 2'd0;
   localparam logic [1:0] ALU_B_FOUR        = 2'd1;
   localparam logic [1:0] ALU_B_IMM         = 2'd2;
   localparam logic [1:0] ALU_B_IMM_SH2     = 2'd3;
   localparam logic [1:0] PC_SRC_ALU        = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT     = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP       = 2'd2;
   localparam logic [1:0] ALU_OP_ADD        = 2'd0;
   localparam logic [1:0] ALU_OP_SUB        = 2'd1;
   localparam logic [1:0] ALU_OP_FUNC       = 2'd2;
   localparam logic [1:0] ALU_OP_OR         = 2'd3;

   // Every datapath control line except the trap flag and debug state
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       imm_ext_mode;
      logic       instr_done;
   } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode: Moore output decode for the multi-cycle controller.
// Control lines come from the state alone, except the FETCH load enables and
// the MEM_WR retire pulse, which wait for the memory ack. While reset is held
// (active_i low) every line is forced to 0.
module mc_out_decode
   import mc_ctrl_pkg::*;
(
   input  logic       active_i,
   input  logic [3:0] state_i,
   input  logic [5:0] opcode_i,
   input  logic       mem_ready_i,
   output ctrl_t      ctrl_o
);

   // Decode the current state (plus latched opcode / ack) into control lines
   always_comb begin
      // NOTE: clearing the whole word first keeps this block free of inferred latches.
      ctrl_o = '0;
      if (active_i) begin
         case (state_i)
            ST_FETCH: begin
               ctrl_o.mem_read  = 1'b1;
               ctrl_o.alu_src_b = ALU_B_FOUR;
               ctrl_o.alu_op    = ALU_OP_ADD;
               ctrl_o.pc_src    = PC_SRC_ALU;
               ctrl_o.ir_write  = mem_ready_i;
               ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
               ctrl_o.alu_src_b    = ALU_B_IMM_SH2;
               ctrl_o.imm_ext_mode = 1'b1;
            end
            ST_MEM_ADDR: begin
               ctrl_o.alu_src_a    = 1'b1;
               ctrl_o.alu_src_b    = ALU_B_IMM;
               ctrl_o.imm_ext_mode = 1'b1;
            end
            ST_MEM_RD: begin
               ctrl_o.mem_read = 1'b1;
               ctrl_o.iord     = 1'b1;
            end
            ST_MEM_WB: begin
               ctrl_o.reg_write  = 1'b1;
               ctrl_o.reg_dst    = REG_DST_RT;
               ctrl_o.mem_to_reg = MEM_TO_REG_MDR;
               ctrl_o.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
               ctrl_o.mem_write  = 1'b1;
               ctrl_o.iord       = 1'b1;
               ctrl_o.instr_done = mem_ready_i;
            end
            ST_R_EXEC: begin
               ctrl_o.alu_src_a = 1'b1;
               ctrl_o.alu_src_b = ALU_B_RT;
               ctrl_o.alu_op    = ALU_OP_FUNC;
            end
            ST_R_WB: begin
               ctrl_o.reg_write  = 1'b1;
               ctrl_o.reg_dst    = REG_DST_RD;
               ctrl_o.mem_to_reg = MEM_TO_REG_ALUOUT;
               ctrl_o.instr_done = 1'b1;
            end
            ST_BRANCH: begin
               ctrl_o.alu_src_a     = 1'b1;
               ctrl_o.alu_op        = ALU_OP_SUB;
               ctrl_o.pc_write_cond = 1'b1;
               ctrl_o.pc_src        = PC_SRC_ALUOUT;
               ctrl_o.instr_done    = 1'b1;
            end
            ST_I_EXEC, ST_I_WB: begin
               // ori zero-extends and ORs; addi sign-extends and adds
               ctrl_o.alu_op       = (opcode_i == OP_ORI) ? ALU_OP_OR : ALU_OP_ADD;
               ctrl_o.imm_ext_mode = (opcode_i != OP_ORI);
               if (state_i == ST_I_EXEC) begin
                  ctrl_o.alu_src_a = 1'b1;
                  ctrl_o.alu_src_b = ALU_B_IMM;
               end else begin
                  ctrl_o.reg_write  = 1'b1;
                  ctrl_o.reg_dst    = REG_DST_RT;
                  ctrl_o.instr_done = 1'b1;
               end
            end
            ST_JUMP: begin
               ctrl_o.pc_write   = 1'b1;
               ctrl_o.pc_src     = PC_SRC_JUMP;
               ctrl_o.instr_done = 1'b1;
               if (opcode_i == OP_JAL) begin
                  ctrl_o.reg_write  = 1'b1;
                  ctrl_o.reg_dst    = REG_DST_RA;
                  ctrl_o.mem_to_reg = MEM_TO_REG_PC;
               end
            end
            default: ;  // TRAP and unused codes drive nothing
         endcase
      end
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: Moore FSM sequencing a multi-cycle MIPS datapath
// (fetch, decode, execute, memory, writeback) over one shared memory with a
// ready handshake. Holds the state register, opcode latch, memory wait counter
// and sticky trap flag; output decode lives in mc_out_decode.
// Optional feature: define MULTI_CYCLE_CTRL_JUMP_EN to execute j/jal through
// the JUMP state; without it opcodes 02/03 trap like any illegal opcode.
module multi_cycle_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0,  // 0 disables the memory timeout
   parameter int unsigned CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_src,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       imm_ext_mode,
   output logic       instr_done,
   output logic       trap,
   output logic [3:0] state
);

`ifdef MULTI_CYCLE_CTRL_JUMP_EN
   localparam bit JUMP_EN = 1'b1;
`else
   localparam bit JUMP_EN = 1'b0;
`endif

   logic [3:0]       state_q, state_d;
   logic [5:0]       opcode_q, opcode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             trap_q, trap_d;
   logic             timeout_hit;
   logic             jump_op;
   ctrl_t            ctrl;

   // The branch decision is made in the datapath by gating pc_write_cond with zero
   logic unused_zero;
   assign unused_zero = zero;

   // This wait cycle is the last one allowed before the access is abandoned
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign jump_op     = (opcode == OP_J) || (opcode == OP_JAL);

   // Next state, opcode latch, wait counter and sticky trap
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      cnt_d    = '0;  // any exit from a wait state leaves the counter cleared
      case (state_q)
         ST_FETCH, ST_MEM_RD, ST_MEM_WR: begin
            if (mem_ready) begin
               if (state_q == ST_FETCH)       state_d = ST_DECODE;
               else if (state_q == ST_MEM_RD) state_d = ST_MEM_WB;
               else                           state_d = ST_FETCH;
            end else if (timeout_hit) begin
               state_d = ST_TRAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DECODE: begin
            opcode_d = opcode;
            case (opcode)
               OP_RTYPE:        state_d = ST_R_EXEC;
               OP_LW, OP_SW:    state_d = ST_MEM_ADDR;
               OP_BEQ:          state_d = ST_BRANCH;
               OP_ADDI, OP_ORI: state_d = ST_I_EXEC;
               default:         state_d = (JUMP_EN && jump_op) ? ST_JUMP : ST_TRAP;
            endcase
         end
         ST_MEM_ADDR: state_d = (opcode_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
         ST_R_EXEC:   state_d = ST_R_WB;
         ST_I_EXEC:   state_d = ST_I_WB;
         ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_I_WB, ST_JUMP: state_d = ST_FETCH;
         default:     state_d = ST_TRAP;  // TRAP is absorbing; stray codes fall into it
      endcase
      trap_d = trap_q | (state_d == ST_TRAP);
   end

   // State and bookkeeping registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_FETCH;
         opcode_q <= '0;
         cnt_q    <= '0;
         trap_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q  <= state_d;
         opcode_q <= opcode_d;
         cnt_q    <= cnt_d;
         trap_q   <= trap_d;
      end
   end

   mc_out_decode u_out_decode (
      .active_i    (rst_n),
      .state_i     (state_q),
      .opcode_i    (opcode_q),
      .mem_ready_i (mem_ready),
      .ctrl_o      (ctrl)
   );

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign pc_src        = ctrl.pc_src;
   assign iord          = ctrl.iord;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign reg_dst       = ctrl.reg_dst;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign imm_ext_mode  = ctrl.imm_ext_mode;
   assign instr_done    = ctrl.instr_done;
   assign trap          = trap_q;
   assign state         = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: self-checking bench for multi_cycle_ctrl.
// A trace model expands each instruction (opcode, fetch wait, memory wait)
// into the cycle-by-cycle sequence of outputs the controller must show; one
// compare process checks the DUT against that trace on every falling edge.
module tb_multi_cycle_ctrl;

   localparam int TO = 5;  // memory timeout used for this build

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       imm_ext_mode;
      logic       instr_done;
      logic       trap;
      logic [3:0] state;
   } obs_t;

   typedef struct {
      obs_t       exp;
      logic       rdy;
      logic [5:0] op;
   } cyc_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       reg_write, alu_src_a, imm_ext_mode, instr_done, trap;
   logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
   logic [3:0] state;
   obs_t       act;

   cyc_t plan[$];
   cyc_t cur;
   bit   cur_valid = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cnt_done, cnt_rw, cnt_memwr, cnt_rdio, cnt_irw;

   multi_cycle_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_src        (pc_src),
      .iord          (iord),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .imm_ext_mode  (imm_ext_mode),
      .instr_done    (instr_done),
      .trap          (trap),
      .state         (state)
   );

   assign act = {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                 imm_ext_mode, instr_done, trap, state};

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic logic [5:0] rnd_op();
      return 6'($urandom);
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom);
   endfunction

   // Output pattern a state must show, from its description (ack-dependent lines excluded)
   function automatic obs_t base(input int st, input logic [5:0] op);
      obs_t e = '0;
      e.state = 4'(st);
      case (st)
         0:  begin e.mem_read = 1'b1; e.alu_src_b = 2'd1; end
         1:  begin e.alu_src_b = 2'd3; e.imm_ext_mode = 1'b1; end
         2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.imm_ext_mode = 1'b1; end
         3:  begin e.mem_read = 1'b1; e.iord = 1'b1; end
         4:  begin e.reg_write = 1'b1; e.mem_to_reg = 2'd1; e.instr_done = 1'b1; end
         5:  begin e.mem_write = 1'b1; e.iord = 1'b1; end
         6:  begin e.alu_src_a = 1'b1; e.alu_op = 2'd2; end
         7:  begin e.reg_write = 1'b1; e.reg_dst = 2'd1; e.instr_done = 1'b1; end
         8:  begin
            e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.pc_write_cond = 1'b1;
            e.pc_src = 2'd1; e.instr_done = 1'b1;
         end
         9, 10: begin
            if (st == 9) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; end
            else begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
            e.alu_op       = (op == 6'h0D) ? 2'd3 : 2'd0;
            e.imm_ext_mode = (op != 6'h0D);
         end
         11: begin
            e.pc_write = 1'b1; e.pc_src = 2'd2; e.instr_done = 1'b1;
            if (op == 6'h03) begin e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; end
         end
         12: e.trap = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   function automatic void push(input obs_t e, input logic rdy, input logic [5:0] op);
      cyc_t c;
      c.exp = e;
      c.rdy = rdy;
      c.op  = op;
      plan.push_back(c);
   endfunction

   // n wait cycles then an ack; returns 1 if the timeout fires first
   function automatic bit mem_phase(input int st, input int n);
      obs_t e;
      for (int w = 0; w <= n; w++) begin
         e = base(st, 6'h00);
         if (w == n) begin
            if (st == 0) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
            if (st == 5) e.instr_done = 1'b1;
            push(e, 1'b1, rnd_op());
            return 1'b0;
         end
         push(e, 1'b0, rnd_op());
         if (w + 1 == TO) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Expand one instruction into its cycle trace; returns 1 if it ends in TRAP
   function automatic bit add_instr(input logic [5:0] op, input int fw, input int mw);
      if (mem_phase(0, fw)) return 1'b1;
      push(base(1, op), rnd_bit(), op);  // only cycle where the opcode input matters
      case (op)
         6'h00: begin push(base(6, op), rnd_bit(), rnd_op()); push(base(7, op), rnd_bit(), rnd_op()); end
         6'h23: begin
            push(base(2, op), rnd_bit(), rnd_op());
            if (mem_phase(3, mw)) return 1'b1;
            push(base(4, op), rnd_bit(), rnd_op());
         end
         6'h2B: begin
            push(base(2, op), rnd_bit(), rnd_op());
            return mem_phase(5, mw);
         end
         6'h04: push(base(8, op), rnd_bit(), rnd_op());
         6'h08, 6'h0D: begin push(base(9, op), rnd_bit(), rnd_op()); push(base(10, op), rnd_bit(), rnd_op()); end
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
         6'h02, 6'h03: push(base(11, op), rnd_bit(), rnd_op());
`endif
         default: return 1'b1;
      endcase
      return 1'b0;
   endfunction

   function automatic void add_trap(input int n);
      for (int i = 0; i < n; i++) push(base(12, 6'h00), rnd_bit(), rnd_op());
   endfunction

   // Drive the planned inputs one cycle at a time, starting just after a rising edge
   task automatic run_plan();
      while (plan.size() > 0) begin
         cur       = plan.pop_front();
         opcode    = cur.op;
         mem_ready = cur.rdy;
         zero      = rnd_bit();
         cur_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      cur_valid = 1'b0;
   endtask

   // Asynchronous reset asserted mid-cycle; released just after a rising edge
   task automatic do_reset();
      #3 rst_n = 1'b0;
      mem_ready = 1'b1;
      opcode    = rnd_op();
      #1 check("reset_outputs", 32'(act), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      rst_n     = 1'b1;
      mem_ready = 1'b0;
      cnt_done = 0; cnt_rw = 0; cnt_memwr = 0; cnt_rdio = 0; cnt_irw = 0;
      #1 check("post_reset_state", {27'd0, trap, state}, 32'd0);
   endtask

   // The single compare process: DUT against trace, every cycle a trace entry is live
   always @(negedge clk) begin
      if (cur_valid) begin
         check($sformatf("cycle_state%0d", cur.exp.state), 32'(act), 32'(cur.exp));
         if (instr_done)          cnt_done++;
         if (reg_write)           cnt_rw++;
         if (mem_write)           cnt_memwr++;
         if (mem_read && iord)    cnt_rdio++;
         if (ir_write)            cnt_irw++;
      end
   end

   initial begin
      logic [5:0] op;
      int         fw, mw;

      #1 do_reset();

      // R-type back to back at zero wait: one retire every 4 cycles
      repeat (3) void'(add_instr(6'h00, 0, 0));
      run_plan();
      check("rtype_instr_done_count", 32'(cnt_done), 32'd3);
      check("rtype_reg_write_count", 32'(cnt_rw), 32'd3);

      // lw with ack delayed 3 cycles in MEM_RD
      do_reset();
      void'(add_instr(6'h23, 0, 3));
      run_plan();
      check("lw_mem_rd_cycles", 32'(cnt_rdio), 32'd4);
      check("lw_reg_write_count", 32'(cnt_rw), 32'd1);

      // sw zero wait: one write cycle, no register write
      do_reset();
      void'(add_instr(6'h2B, 0, 0));
      run_plan();
      check("sw_mem_write_cycles", 32'(cnt_memwr), 32'd1);
      check("sw_reg_write_count", 32'(cnt_rw), 32'd0);

      // beq twice, addi, ori, lw just under the timeout
      do_reset();
      void'(add_instr(6'h04, 1, 0));
      void'(add_instr(6'h04, 0, 0));
      void'(add_instr(6'h08, 2, 0));
      void'(add_instr(6'h0D, 0, 0));
      void'(add_instr(6'h23, 4, TO - 1));
      run_plan();
      check("mixed_instr_done_count", 32'(cnt_done), 32'd5);

      // Illegal opcode traps after DECODE and stays trapped
      do_reset();
      if (add_instr(6'h3F, 0, 0)) add_trap(20);
      run_plan();
      check("illegal_trap_flag", 32'(trap), 32'd1);
      check("illegal_fetch_count", 32'(cnt_irw), 32'd1);

      // j and jal: trap in the default build, JUMP with the feature
      do_reset();
      if (add_instr(6'h02, 0, 0)) add_trap(20);
      else if (add_instr(6'h03, 0, 0)) add_trap(5);
      run_plan();

      // Fetch never acknowledged: trap after TO wait cycles, no instruction latched
      do_reset();
      if (add_instr(6'h00, TO + 3, 0)) add_trap(5);
      run_plan();
      check("fetch_timeout_ir_write", 32'(cnt_irw), 32'd0);
      check("fetch_timeout_trap", 32'(trap), 32'd1);

      // Store never acknowledged: TO write cycles, then no strobe in TRAP
      do_reset();
      if (add_instr(6'h2B, 0, TO)) add_trap(5);
      run_plan();
      check("sw_timeout_write_cycles", 32'(cnt_memwr), 32'(TO));
      check("sw_timeout_no_retire", 32'(cnt_done), 32'd0);

      // Load never acknowledged
      do_reset();
      if (add_instr(6'h23, 0, TO + 2)) add_trap(3);
      run_plan();

      // Reset pulsed in the middle of a stalled fetch
      do_reset();
      mem_ready = 1'b0;
      @(negedge clk);
      check("stalled_fetch_mem_read", {31'd0, mem_read}, 32'd1);
      do_reset();

      // Randomized instruction streams
      for (int ep = 0; ep < 12; ep++) begin
         do_reset();
         for (int k = 0; k < 15; k++) begin
            case ($urandom_range(0, 9))
               0: op = 6'h00;
               1: op = 6'h23;
               2: op = 6'h2B;
               3: op = 6'h04;
               4: op = 6'h08;
               5: op = 6'h0D;
               6: op = 6'h02;
               7: op = 6'h03;
               8: op = rnd_op();
               default: op = 6'h00;
            endcase
            fw = ($urandom_range(0, 29) == 0) ? TO + 1 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, TO - 1));
            if (add_instr(op, fw, mw)) begin
               add_trap(4);
               break;
            end
         end
         run_plan();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
